// File: rtl/alu_sequencer_if.sv
// alu_sequencer_if: instruction-issue and result-return handshakes between decode and alu_sequencer.
interface alu_sequencer_if #(
    parameter int WORD_SIZE = 32,
    parameter int REG_AW    = 3,
    parameter int IMM_W     = 8
);
    logic                 instr_valid;
    logic                 instr_ready;
    logic [3:0]           instr_op;
    logic [REG_AW-1:0]    instr_rd;
    logic [REG_AW-1:0]    instr_rs1;
    logic [REG_AW-1:0]    instr_rs2;
    logic                 instr_imm_en;
    logic [IMM_W-1:0]     instr_imm;
    logic                 res_valid;
    logic                 res_ready;
    logic [WORD_SIZE-1:0] res_data;
    logic [REG_AW-1:0]    res_rd;
    logic                 res_err;
    modport master (
        output instr_valid, instr_op, instr_rd, instr_rs1, instr_rs2, instr_imm_en, instr_imm, res_ready,
        input  instr_ready, res_valid, res_data, res_rd, res_err
    );
    modport slave (
        input  instr_valid, instr_op, instr_rd, instr_rs1, instr_rs2, instr_imm_en, instr_imm, res_ready,
        output instr_ready, res_valid, res_data, res_rd, res_err
    );
endinterface

// File: rtl/alu_sequencer.sv
// alu_sequencer: issues one instruction at a time to a registered ALU, writes back rd and returns the result.
module alu_sequencer #(
    parameter int WORD_SIZE = 32,
    parameter int NUM_REGS  = 8,
    parameter int REG_AW    = 3,
    parameter int IMM_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_sequencer_if.slave       seq,
    output logic [3:0]           alu_op_o,
    output logic [WORD_SIZE-1:0] alu_in1_o,
    output logic [WORD_SIZE-1:0] alu_in2_o,
    output logic                 alu_able_o,
    input  logic [WORD_SIZE-1:0] alu_out_i,
    input  logic [REG_AW-1:0]    dbg_addr_i,
    output logic [WORD_SIZE-1:0] dbg_data_o
);
    // Opcodes 0..8 are ADD SUB MUL SLT AND OR XOR LSHIFT RSHIFT; RSHIFT is the highest valid code.
    localparam logic [3:0] ALU_RSHIFT = 4'd8;

    typedef enum logic [1:0] {IDLE, EXEC, CAPT, RESP} state_t;

    state_t               state_q;
    logic [WORD_SIZE-1:0] regs_q [NUM_REGS];
    logic [3:0]           op_q;
    logic [WORD_SIZE-1:0] in1_q, in2_q, res_data_q;
    logic [REG_AW-1:0]    rd_q;
    logic                 able_q, res_valid_q, res_err_q;
    logic [WORD_SIZE-1:0] in1_d, in2_d;
    logic                 op_ok_d;

    // r0 is never written, so its reset value keeps it reading as zero.
    always_comb begin
        in1_d   = regs_q[seq.instr_rs1];
        in2_d   = seq.instr_imm_en ? WORD_SIZE'(seq.instr_imm) : regs_q[seq.instr_rs2];
        op_ok_d = seq.instr_op <= ALU_RSHIFT;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
            op_q        <= '0;
            in1_q       <= '0;
            in2_q       <= '0;
            rd_q        <= '0;
            able_q      <= 1'b0;
            res_valid_q <= 1'b0;
            res_err_q   <= 1'b0;
            res_data_q  <= '0;
        end else begin
            case (state_q)
                IDLE: if (seq.instr_valid) begin
                    op_q        <= seq.instr_op;
                    rd_q        <= seq.instr_rd;
                    in1_q       <= in1_d;
                    in2_q       <= in2_d;
                    able_q      <= op_ok_d;
                    res_valid_q <= !op_ok_d;
                    res_err_q   <= !op_ok_d;
                    res_data_q  <= '0;
                    state_q     <= op_ok_d ? EXEC : RESP;
                end
                EXEC: begin
                    able_q  <= 1'b0;
                    state_q <= CAPT;
                end
                CAPT: begin
                    res_data_q  <= alu_out_i;
                    if (rd_q != '0) regs_q[rd_q] <= alu_out_i;
                    res_err_q   <= 1'b0;
                    res_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
                RESP: if (seq.res_ready) begin
                    res_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign seq.instr_ready = state_q == IDLE;
    assign seq.res_valid   = res_valid_q;
    assign seq.res_data    = res_data_q;
    assign seq.res_rd      = rd_q;
    assign seq.res_err     = res_err_q;
    assign alu_op_o        = op_q;
    assign alu_in1_o       = in1_q;
    assign alu_in2_o       = in2_q;
    assign alu_able_o      = able_q;
    assign dbg_data_o      = regs_q[dbg_addr_i];
endmodule
